// File: rtl/uart_activity_pkg.sv
// Shared types and helpers for the serial-line activity LED blocks.
package uart_activity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic MODE_STRETCH = 1'b0;
  localparam logic MODE_BLINK   = 1'b1;

  // Counter width big enough for the longer of the on and off phases.
  function automatic int calc_cnt_w(input int on_cycles, input int off_cycles);
    int max_cycles;
    max_cycles = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return (max_cycles > 2) ? $clog2(max_cycles) : 1;
  endfunction

endpackage

// File: rtl/uart_activity_chan.sv
// One activity channel: synchronizer, edge detect, on/gap FSM, counter and pending flag.
module uart_activity_chan
  import uart_activity_pkg::*;
#(
  parameter int   ON_CYCLES   = 33554432,
  parameter int   OFF_CYCLES  = 8388608,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  input  logic mode,
  output logic led_n,
  output logic act_pulse
);

  localparam int               CNT_W    = calc_cnt_w(ON_CYCLES, OFF_CYCLES);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   last_active_r;
  logic                   active_s;
  logic                   edge_s;
  state_e                 state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic                   pend_r, pend_s;
  logic                   chan_mode_r, chan_mode_s;
  logic                   led_n_r;
  logic                   act_pulse_r;

  assign active_s  = (sync_r[SYNC_STAGES-1] != IDLE_LEVEL);
  assign edge_s    = active_s & ~last_active_r;
  assign led_n     = led_n_r;
  assign act_pulse = act_pulse_r;

  // Synchronizer chain and edge-detect history; flops reset to the idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r        <= {SYNC_STAGES{IDLE_LEVEL}};
      last_active_r <= 1'b0;
    end else begin
      sync_r        <= {sync_r[SYNC_STAGES-2:0], line};
      last_active_r <= active_s;
    end
  end

  // FSM next state: terminal compare is checked before incrementing so the counter never wraps.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    pend_s      = pend_r;
    chan_mode_s = chan_mode_r;
    case (state_r)
      IDLE: begin
        if (active_s) begin
          state_s     = ON;
          cnt_s       = '0;
          pend_s      = 1'b0;
          chan_mode_s = mode;
        end else begin
          state_s = IDLE;
        end
      end
      ON: begin
        if ((chan_mode_r == MODE_STRETCH) && active_s) begin
          cnt_s = '0;
        end else if (cnt_r == ON_LAST) begin
          cnt_s = '0;
          if (chan_mode_r == MODE_STRETCH) begin
            state_s = IDLE;
          end else begin
            state_s = GAP;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
        if ((chan_mode_r == MODE_BLINK) && active_s) begin
          pend_s = 1'b1;
        end else begin
          pend_s = pend_r;
        end
      end
      GAP: begin
        if (cnt_r == OFF_LAST) begin
          cnt_s  = '0;
          pend_s = 1'b0;
          if (pend_r || active_s) begin
            state_s = ON;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s  = cnt_r + CNT_ONE;
          pend_s = pend_r | active_s;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        pend_s  = 1'b0;
      end
    endcase
  end

  // State, counter and registered LED/pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      pend_r      <= 1'b0;
      chan_mode_r <= MODE_STRETCH;
      led_n_r     <= 1'b1;
      act_pulse_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      pend_r      <= pend_s;
      chan_mode_r <= chan_mode_s;
      led_n_r     <= (state_s != ON);
      act_pulse_r <= edge_s;
    end
  end

endmodule

// File: rtl/uart_activity_led.sv
// Multi-channel serial activity LED driver; one independent channel per line.
module uart_activity_led
  import uart_activity_pkg::*;
#(
  parameter int   CHANNELS    = 2,
  parameter int   ON_CYCLES   = 33554432,
  parameter int   OFF_CYCLES  = 8388608,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] line_in,
  input  logic                mode,
  output logic [CHANNELS-1:0] led_n,
  output logic [CHANNELS-1:0] act_pulse
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    uart_activity_chan #(
      .ON_CYCLES  (ON_CYCLES),
      .OFF_CYCLES (OFF_CYCLES),
      .SYNC_STAGES(SYNC_STAGES),
      .IDLE_LEVEL (IDLE_LEVEL)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .line     (line_in[i]),
      .mode     (mode),
      .led_n    (led_n[i]),
      .act_pulse(act_pulse[i])
    );
  end

endmodule

// File: tb/tb_uart_activity_led.sv
// Directed bench for uart_activity_led with ON_CYCLES=8, OFF_CYCLES=4, two channels.
module tb_uart_activity_led;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] line_in;
  logic       mode;
  logic [1:0] led_n;
  logic [1:0] act_pulse;

  int total = 0;
  int bad   = 0;

  logic exp_low;
  logic exp_act;

  always #5 clk = ~clk;

  uart_activity_led #(
    .CHANNELS   (2),
    .ON_CYCLES  (8),
    .OFF_CYCLES (4),
    .SYNC_STAGES(2),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (line_in),
    .mode     (mode),
    .led_n    (led_n),
    .act_pulse(act_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check_val(tag, {led_n, act_pulse}, {2'b11, 2'b00});
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    line_in = 2'b11;
    mode    = 1'b0;

    // Reset held with idle lines, then released.
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("rst_led", led_n, 2'b11);
      check_val("rst_act", act_pulse, 2'b00);
    end
    rst_n = 1'b1;
    idle_ticks(5, "post_rst");

    // Single-cycle low on ch0 in stretch mode: on after edges 2..9.
    for (int k = 0; k < 16; k++) begin
      line_in[0] = (k == 0) ? 1'b0 : 1'b1;
      tick();
      exp_low = (k >= 2 && k <= 9);
      exp_act = (k == 2);
      check_val("t2_led", led_n, {1'b1, ~exp_low});
      check_val("t2_act", act_pulse, {1'b0, exp_act});
    end
    idle_ticks(3, "t2_idle");

    // Stretch retrigger on ch1: lows sampled every 5 edges, last at 35.
    for (int k = 0; k < 55; k++) begin
      line_in[1] = ((k % 5 == 0) && (k < 40)) ? 1'b0 : 1'b1;
      tick();
      exp_low = (k >= 2 && k <= 44);
      exp_act = (k >= 2 && k <= 37 && ((k - 2) % 5 == 0));
      check_val("t3_led", led_n, {~exp_low, 1'b1});
      check_val("t3_act", act_pulse, {exp_act, 1'b0});
    end
    idle_ticks(3, "t3_idle");

    // Blink with ch0 held low for samples 0..36: 8 on / 4 off, ends idle after edge 49.
    mode = 1'b1;
    idle_ticks(2, "t4_pre");
    for (int k = 0; k < 63; k++) begin
      line_in[0] = (k <= 36) ? 1'b0 : 1'b1;
      tick();
      exp_low = (k >= 2 && k <= 45 && (((k - 2) % 12) < 8));
      exp_act = (k == 2);
      check_val("t4_led", led_n, {1'b1, ~exp_low});
      check_val("t4_act", act_pulse, {1'b0, exp_act});
    end
    mode = 1'b0;
    idle_ticks(3, "t4_idle");

    // Mode flips mid-stretch; first burst stays stretch, second burst blinks.
    for (int k = 0; k < 51; k++) begin
      line_in[0] = ((k == 0) || (k == 6) || (k >= 20 && k <= 31)) ? 1'b0 : 1'b1;
      if (k == 4) begin
        mode = 1'b1;
      end
      tick();
      exp_low = (k >= 2 && k <= 15) || (k >= 22 && k <= 29) || (k >= 34 && k <= 41);
      exp_act = (k == 2) || (k == 8) || (k == 22);
      check_val("t5_led", led_n, {1'b1, ~exp_low});
      check_val("t5_act", act_pulse, {1'b0, exp_act});
    end
    mode = 1'b0;
    idle_ticks(3, "t5_idle");

    // One-cycle reset while ch0 is on at count 5.
    for (int k = 0; k < 21; k++) begin
      line_in[0] = (k == 0) ? 1'b0 : 1'b1;
      rst_n      = (k == 8) ? 1'b0 : 1'b1;
      tick();
      exp_low = (k >= 2 && k <= 7);
      exp_act = (k == 2);
      check_val("t6_led", led_n, {1'b1, ~exp_low});
      check_val("t6_act", act_pulse, {1'b0, exp_act});
    end
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
